// File: rtl/branch_predictor.sv
// branch_predictor
//   Direct-mapped BTB with 2-bit saturating counters for the 5-stage RV32 core.
//   F stage: combinational lookup of pc_f_i gives a predicted direction and a
//   next PC. E stage: the resolved outcome trains the table on the next clock
//   edge. A wrong guess raises mispredict_e_o together with the recovery PC.
//
//   Optional statistics counters are built when BRANCH_PREDICTOR_STATS_EN is
//   defined. Otherwise both statistics outputs are tied to 0.
//
// Ports
//   clk, rst_n_i              clock (rising edge), async active-low reset
//   pc_f_i, lookup_en_i       fetch PC, fetch-advancing strobe (stats only)
//   predict_taken_f_o         predicted taken for pc_f_i
//   predict_target_f_o        BTB target if predicted taken, else pc_f_i+4
//   update_*_e_i              resolved branch/jump from E
//   pred_taken_e_i            F-stage prediction, piped to E
//   pred_target_e_i           F-stage predicted next PC, piped to E
//   mispredict_e_o            F guessed wrong; flush and redirect
//   recover_pc_e_o            correct next PC
//   lookup_count_o            statistics counter
//   mispredict_count_o        statistics counter
module branch_predictor #(
  parameter int DATA_WIDTH = 32,
  parameter int ENTRIES    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n_i,
  input  logic [DATA_WIDTH-1:0] pc_f_i,
  input  logic                  lookup_en_i,
  output logic                  predict_taken_f_o,
  output logic [DATA_WIDTH-1:0] predict_target_f_o,
  input  logic                  update_valid_e_i,
  input  logic                  update_jump_e_i,
  input  logic                  update_jalr_e_i,
  input  logic [DATA_WIDTH-1:0] update_pc_e_i,
  input  logic                  update_taken_e_i,
  input  logic [DATA_WIDTH-1:0] update_target_e_i,
  input  logic                  pred_taken_e_i,
  input  logic [DATA_WIDTH-1:0] pred_target_e_i,
  output logic                  mispredict_e_o,
  output logic [DATA_WIDTH-1:0] recover_pc_e_o,
  output logic [31:0]           lookup_count_o,
  output logic [31:0]           mispredict_count_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = DATA_WIDTH - IDX_W - 2;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

  logic                  valid_q  [ENTRIES];
  logic                  valid_d  [ENTRIES];
  logic [TAG_W-1:0]      tag_q    [ENTRIES];
  logic [TAG_W-1:0]      tag_d    [ENTRIES];
  logic [DATA_WIDTH-1:0] target_q [ENTRIES];
  logic [DATA_WIDTH-1:0] target_d [ENTRIES];
  logic [1:0]            ctr_q    [ENTRIES];
  logic [1:0]            ctr_d    [ENTRIES];

  // Lookup: reads only the registered table, so a same-cycle update to the
  // same index is not bypassed.
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;

  assign f_idx = pc_f_i[IDX_W+1:2];
  assign f_tag = pc_f_i[DATA_WIDTH-1:IDX_W+2];
  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

  assign predict_taken_f_o  = f_hit && ctr_q[f_idx][1];
  assign predict_target_f_o = predict_taken_f_o ? target_q[f_idx] : pc_f_i + PC_STEP;

  // Resolution
  logic [IDX_W-1:0] e_idx;
  logic [TAG_W-1:0] e_tag;
  logic             e_hit;

  assign e_idx = update_pc_e_i[IDX_W+1:2];
  assign e_tag = update_pc_e_i[DATA_WIDTH-1:IDX_W+2];
  assign e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);

  assign mispredict_e_o = update_valid_e_i &&
                          ((update_taken_e_i != pred_taken_e_i) ||
                           (update_taken_e_i && pred_taken_e_i &&
                            (update_target_e_i != pred_target_e_i)));

  assign recover_pc_e_o = update_taken_e_i ? update_target_e_i : update_pc_e_i + PC_STEP;

  // Training. JALR targets are register-dependent, so they never touch the table.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (update_valid_e_i && !update_jalr_e_i) begin
      if (e_hit) begin
        if (update_taken_e_i) begin
          if (ctr_q[e_idx] != CTR_ST) ctr_d[e_idx] = ctr_q[e_idx] + 2'd1;
          target_d[e_idx] = update_target_e_i;
        end else if (ctr_q[e_idx] != CTR_SNT) begin
          ctr_d[e_idx] = ctr_q[e_idx] - 2'd1;
        end
      end else if (update_taken_e_i) begin
        valid_d[e_idx]  = 1'b1;
        tag_d[e_idx]    = e_tag;
        target_d[e_idx] = update_target_e_i;
        ctr_d[e_idx]    = update_jump_e_i ? CTR_ST : CTR_WT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end

`ifdef BRANCH_PREDICTOR_STATS_EN
  logic [31:0] lookup_count_q, lookup_count_d;
  logic [31:0] mispredict_count_q, mispredict_count_d;

  always_comb begin
    lookup_count_d     = lookup_count_q + {31'd0, lookup_en_i};
    mispredict_count_d = mispredict_count_q + {31'd0, mispredict_e_o};
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lookup_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      lookup_count_q     <= lookup_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign lookup_count_o     = lookup_count_q;
  assign mispredict_count_o = mispredict_count_q;
`else
  logic unused_lookup_en;
  assign unused_lookup_en   = lookup_en_i;
  assign lookup_count_o     = '0;
  assign mispredict_count_o = '0;
`endif

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor for the 5-stage pipelined RV32 core. It replaces static predict-not-taken: F stage is redirected to a predicted target in the same cycle it fetches a branch/JAL. E stage reports resolved outcomes, which train a direct-mapped branch target buffer with 2-bit saturating counters. On a wrong guess it raises a mispredict and supplies the recovery PC, which drives the PC mux and the flush logic.

## Interface
- DATA_WIDTH, 32, PC/target width
- ENTRIES, 16, BTB entries; power of two, 2..256
- Derived: IDX_W = log2(ENTRIES); TAG_W = DATA_WIDTH-IDX_W-2; index = pc[IDX_W+1:2], tag = pc[DATA_WIDTH-1:IDX_W+2]
- clk  in  1  clock, rising edge
- rst_n_i  in  1  asynchronous active-low reset
- pc_f_i  in  DATA_WIDTH  fetch PC
- lookup_en_i  in  1  fetch advancing (~stall_f); only used for statistics
- predict_taken_f_o  out  1  predicted taken for pc_f_i
- predict_target_f_o  out  DATA_WIDTH  next PC: BTB target if predicted taken, else pc_f_i+4
- update_valid_e_i  in  1  E holds a resolved branch or jump this cycle (not asserted when flush_e)
- update_jump_e_i  in  1  instruction is JAL (unconditional)
- update_jalr_e_i  in  1  instruction is JALR
- update_pc_e_i  in  DATA_WIDTH  PC of resolved instruction
- update_taken_e_i  in  1  actual outcome
- update_target_e_i  in  DATA_WIDTH  actual taken target
- pred_taken_e_i  in  1  prediction made in F, piped to E
- pred_target_e_i  in  DATA_WIDTH  predicted next PC, piped to E
- mispredict_e_o  out  1  prediction wrong; flush D/E, redirect F
- recover_pc_e_o  out  DATA_WIDTH  correct next PC
- lookup_count_o  out  32  statistics (see Configuration)
- mispredict_count_o  out  32  statistics

## Operation
- Per entry: valid, tag[TAG_W], target[DATA_WIDTH], ctr[2]. Counter states: SNT=00, WNT=01, WT=10, ST=11.
- Lookup (combinational):
  - Hit when valid and tag matches.
  - predict_taken_f_o = hit & ctr[1].
- Update, registered at posedge when update_valid_e_i=1:
  - JALR: no table change. Its target is register-dependent and never predicted.
  - Hit, taken: ctr saturating +1 (ST stays ST); target <= update_target_e_i.
  - Hit, not taken: ctr saturating -1 (SNT stays SNT); target unchanged.
  - Miss, taken, conditional branch: allocate (overwrite) entry with valid=1, tag, target, ctr=WT.
  - Miss, taken, JAL: allocate with ctr=ST.
  - Miss, not taken: no allocation.
- Mispredict (combinational; 0 when update_valid_e_i=0):
  - Asserted when update_taken_e_i != pred_taken_e_i.
  - Also asserted when both are 1 and update_target_e_i != pred_target_e_i.
- recover_pc_e_o:
  - update_target_e_i when taken, else update_pc_e_i+4.
  - Driven even when mispredict_e_o=0.
- All PC arithmetic is modulo 2^DATA_WIDTH; pc+4 wraps at all-ones.

## Timing
- Lookup: zero latency, combinational from pc_f_i.
- Update: one cycle; visible to lookups from the cycle after the update edge.
- Same-cycle lookup and update to the same index: lookup returns the pre-update entry (no bypass).
- mispredict_e_o / recover_pc_e_o: combinational in the E cycle. Recovery PC is fetched the next cycle.
- Reset (async assert, sync-released by top level):
  - All valid=0; ctr=WNT; targets/tags 0; statistics 0.
  - Hence predict_taken_f_o=0 and predict_target_f_o=pc_f_i+4.
- Reset mid-operation: the table is cleared immediately and an in-flight update is discarded.

## Configuration
- BRANCH_PREDICTOR_STATS_EN defined:
  - lookup_count_o increments on each cycle with lookup_en_i=1.
  - mispredict_count_o increments on each cycle with mispredict_e_o=1.
  - Both counters are 32-bit, wrap at 2^32, and reset to 0.
- Not defined: both outputs are tied to 0 and no counter flops are synthesised. Prediction behaviour is identical either way.

## Test plan
- Reset, pc_f_i=0x100 -> predict_taken_f_o=0, predict_target_f_o=0x104; both statistics outputs 0.
- Branch at 0x200, target 0x180, taken three times:
  - 1st update: mispredict_e_o=1, recover_pc_e_o=0x180.
  - Next lookup of 0x200: taken, target 0x180 (ctr=WT).
  - Third update: ctr=ST.
- From ST, two not-taken updates -> ctr WT then WNT:
  - First: mispredict_e_o=1, recover_pc_e_o=0x204.
  - Subsequent lookup of 0x200 predicts 0x204.
- Aliasing, ENTRIES=16: JAL at 0x40 (target 0x80) then taken branch at 0x80 (same index 0, target 0x10):
  - Second allocation evicts the first.
  - Lookup 0x40 -> not taken, 0x44.
- JALR update at 0x300, target 0x500, pred_taken_e_i=0 -> mispredict_e_o=1, recover 0x500; table unchanged, lookup 0x300 -> 0x304.
- Same-cycle update and lookup at 0x200 from empty table -> lookup returns not taken; next cycle returns taken. With BRANCH_PREDICTOR_STATS_EN, 10 lookup_en_i cycles and 2 mispredicts -> counts 10 and 2.
